// File: rtl/crc16_pkg.sv
// crc16_pkg: shared widths, CRC polynomial and packer state encoding
// Contents:
//   DATA_W, CRC_W, BYTES_PER_WORD : word geometry shared by crc16 and the packer
//   CRC_POLY                      : CRC-16 polynomial x^16 + x^15 + x^2 + 1
//   state_e                       : packer FSM states FILL -> CRC -> SEND
package crc16_pkg;
    localparam int DATA_W = 64;
    localparam int CRC_W = 16;
    localparam int BYTES_PER_WORD = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 16'h8005;
    typedef enum logic [1:0] {FILL, CRC, SEND} state_e;
endpackage

// File: rtl/crc16.sv
// crc16: registered CRC-16 of a 64-bit word, polynomial 0x8005, zero seed
// Ports:
//   clk     in   1       clock, posedge
//   rst     in   1       synchronous active-high reset, clears the CRC register
//   data_in in   DATA_W  word to protect, processed from bit DATA_W-1 down to bit 0
//   crc_out out  CRC_W   CRC of the data_in seen on the previous clock edge
module crc16
    import crc16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    output logic [CRC_W-1:0]  crc_out
);
    logic [CRC_W-1:0] lfsr_d, lfsr_q;
    // Whole word folded in one cycle; the result equals data_in * x^16 mod poly.
    always_comb begin
        lfsr_d = '0;
        for (int i = DATA_W - 1; i >= 0; i--)
            lfsr_d = {lfsr_d[CRC_W-2:0], 1'b0} ^ ((lfsr_d[CRC_W-1] ^ data_in[i]) ? CRC_POLY : '0);
    end
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= '0;
        else     lfsr_q <= lfsr_d;
    end
    assign crc_out = lfsr_q;
endmodule

// File: rtl/crc16_frame_packer.sv
// crc16_frame_packer: packs a byte stream into 64-bit words and emits {word, crc16}
// Ports:
//   clk        in   1   clock, posedge
//   rst        in   1   synchronous active-high reset (also resets crc16)
//   in_data    in   8   input byte
//   in_valid   in   1   in_data valid
//   in_ready   out  1   byte accepted when in_valid & in_ready
//   in_last    in   1   last byte of frame (PACKER_PAD_EN builds only)
//   out_data   out  64  packed word
//   out_crc    out  16  crc16 of out_data
//   out_bytes  out  4   valid bytes in out_data, 1..8 (PACKER_PAD_EN builds only)
//   out_valid  out  1   out_data/out_crc valid
//   out_ready  in   1   word taken when out_valid & out_ready
// Parameter LSB_FIRST: 1 puts the first byte in data[7:0], 0 puts it in data[63:56].
// Macro PACKER_PAD_EN: enables in_last/out_bytes so short frames close a word early.
module crc16_frame_packer
    import crc16_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
`ifdef PACKER_PAD_EN
    input  logic              in_last,
    output logic [3:0]        out_bytes,
`endif
    output logic [DATA_W-1:0] out_data,
    output logic [CRC_W-1:0]  out_crc,
    output logic              out_valid,
    input  logic              out_ready
);
    state_e            state_d, state_q;
    logic [2:0]        cnt_d, cnt_q;
    logic [DATA_W-1:0] word_d, word_q;
    logic [2:0]        slot;
    logic              take, close;
    assign take = (state_q == FILL) && in_valid;
`ifdef PACKER_PAD_EN
    assign close = (cnt_q == 3'(BYTES_PER_WORD - 1)) || in_last;
`else
    assign close = (cnt_q == 3'(BYTES_PER_WORD - 1));
`endif
    assign slot = LSB_FIRST ? cnt_q : 3'(BYTES_PER_WORD - 1) - cnt_q;
    // Unwritten slots are always zero (cleared on reset and on send), so OR-in suffices.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        case (state_q)
            FILL: if (in_valid) begin
                word_d  = word_q | ({{(DATA_W-8){1'b0}}, in_data} << {slot, 3'b000});
                cnt_d   = close ? 3'd0 : cnt_q + 3'd1;
                state_d = close ? CRC : FILL;
            end
            CRC:  state_d = SEND;
            SEND: if (out_ready) begin
                word_d  = '0;
                state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end
`ifdef PACKER_PAD_EN
    logic [3:0] bytes_d, bytes_q;
    always_comb begin
        bytes_d = bytes_q;
        if (take && close)
            bytes_d = {1'b0, cnt_q} + 4'd1;
        else if (state_q == SEND && out_ready)
            bytes_d = '0;
    end
    always_ff @(posedge clk) begin
        if (rst) bytes_q <= '0;
        else     bytes_q <= bytes_d;
    end
    assign out_bytes = bytes_q;
`else
    logic unused_take;
    assign unused_take = take;
`endif
    // The word is stable through CRC and SEND, so crc16 keeps presenting its CRC.
    crc16 u_crc16 (
        .clk     (clk),
        .rst     (rst),
        .data_in (word_q),
        .crc_out (out_crc)
    );
    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == SEND);
    assign out_data  = word_q;
endmodule

// File: tb/tb_crc16_frame_packer.sv
// tb_crc16_frame_packer: directed self-checking bench for crc16_frame_packer (LSB- and MSB-first)
module tb_crc16_frame_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready, m_in_ready;
    logic [63:0] out_data, m_out_data;
    logic [15:0] out_crc, m_out_crc;
    logic        out_valid, m_out_valid;
`ifdef PACKER_PAD_EN
    logic        in_last;
    logic [3:0]  out_bytes, m_out_bytes;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    crc16_frame_packer #(.LSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef PACKER_PAD_EN
        .in_last(in_last), .out_bytes(out_bytes),
`endif
        .out_data(out_data), .out_crc(out_crc), .out_valid(out_valid), .out_ready(out_ready)
    );

    crc16_frame_packer #(.LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_in_ready),
`ifdef PACKER_PAD_EN
        .in_last(in_last), .out_bytes(m_out_bytes),
`endif
        .out_data(m_out_data), .out_crc(m_out_crc), .out_valid(m_out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("push_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // bytes_in[7:0] is sent first; checks the two-cycle latency to out_valid
    task automatic push8(input string tag, input logic [63:0] bytes_in);
        for (int i = 0; i < 8; i++) push(bytes_in[8*i +: 8]);
        chk({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_lat2"}, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic expect_word(input string tag, input logic [63:0] d, input logic [15:0] c,
                               input logic [63:0] md, input logic [15:0] mc);
        chk({tag, "_valid"}, {63'd0, out_valid & m_out_valid}, 64'd1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_crc"}, {48'd0, out_crc}, {48'd0, c});
        chk({tag, "_mdata"}, m_out_data, md);
        chk({tag, "_mcrc"}, {48'd0, m_out_crc}, {48'd0, mc});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_vdrop"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        rst = 1'b1;
        in_data = 8'h00;
        in_valid = 1'b0;
        out_ready = 1'b0;
`ifdef PACKER_PAD_EN
        in_last = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_crc", {48'd0, out_crc}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, in_ready}, 64'd1);

        push8("zero", 64'h0);
        expect_word("zero", 64'h0, 16'h0000, 64'h0, 16'h0000);

        push8("one", 64'h01);
        expect_word("one", 64'h1, 16'h8005, 64'h0100_0000_0000_0000, 16'h1006);

        push8("top", 64'h8000_0000_0000_0000);
        expect_word("top", 64'h8000_0000_0000_0000, 16'h8333, 64'h80, 16'h8303);

        push8("hold", 64'h01);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", out_data, 64'h1);
            chk("hold_crc", {48'd0, out_crc}, 64'h8005);
            chk("hold_inrdy", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        expect_word("hold", 64'h1, 16'h8005, 64'h0100_0000_0000_0000, 16'h1006);
        push8("after", 64'h02);
        expect_word("after", 64'h2, 16'h800F, 64'h0200_0000_0000_0000, 16'h200C);

        for (int i = 0; i < 4; i++) push(8'hFF);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_data", out_data, 64'h0);
        chk("mrst_mdata", m_out_data, 64'h0);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || m_out_valid) vcount++;
        end
        chk("mrst_noout", 64'(vcount), 64'd0);
        push8("mrst", 64'h01);
        expect_word("mrst", 64'h1, 16'h8005, 64'h0100_0000_0000_0000, 16'h1006);

`ifdef PACKER_PAD_EN
        push(8'h01);
        push(8'h00);
        in_last = 1'b1;
        push(8'h00);
        in_last = 1'b0;
        @(posedge clk);
        #1;
        chk("pad_bytes", {60'd0, out_bytes}, 64'd3);
        chk("pad_mbytes", {60'd0, m_out_bytes}, 64'd3);
        expect_word("pad", 64'h1, 16'h8005, 64'h0100_0000_0000_0000, 16'h1006);
        push8("full", 64'h01);
        chk("full_bytes", {60'd0, out_bytes}, 64'd8);
        expect_word("full", 64'h1, 16'h8005, 64'h0100_0000_0000_0000, 16'h1006);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
